// File: rtl/rst_wdt_ctrl_pkg.sv
// Shared FSM state encoding for the reset sequencer / run watchdog.
package rst_wdt_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ASSERT  = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/rst_wdt_ctrl_rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after SYNC_STAGES clock edges.
module rst_wdt_ctrl_rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_no = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_wdt_ctrl.sv
// Staggered reset sequencer with run watchdog and sticky timeout/done flags.
// Optional status counters (run_cycles, sw_rst_cnt) enabled by RST_WDT_STATUS_EN.
module rst_wdt_ctrl
    import rst_wdt_ctrl_pkg::*;
#(
    parameter int NUM_RST     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 3,
    parameter int STAGGER     = 4,
    parameter int TIMEOUT     = 50,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_rst_req,
    input  logic               kick,
    input  logic               done_in,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               running,
    output logic               timeout,
    output logic               done
`ifdef RST_WDT_STATUS_EN
    ,
    output logic [31:0]        run_cycles,
    output logic [7:0]         sw_rst_cnt
`endif
);

    localparam int              IDX_W    = $clog2(NUM_RST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] PULSE_LIM = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] STAG_LIM = CNT_W'(STAGGER);
    localparam logic [CNT_W-1:0] WDT_LIM  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              WDT_EN   = (TIMEOUT > 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_RST-1:0] rst_out_q, rst_out_d;
    logic               running_q, running_d;
    logic               timeout_q, timeout_d;
    logic               done_q, done_d;
    logic               rst_synced;

    rst_wdt_ctrl_rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .rst_no (rst_synced)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // One shared counter: pulse length in ASSERT, channel spacing in RELEASE, idle cycles in RUN.
    // A software request counts its own cycle as the first low cycle of the new pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        running_d = running_q;
        timeout_d = timeout_q;
        done_d    = done_q;

        if (!rst_synced) begin
            state_d   = ST_ASSERT;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '0;
            running_d = 1'b0;
            timeout_d = 1'b0;
            done_d    = 1'b0;
        end else if (sw_rst_req) begin
            state_d   = ST_ASSERT;
            cnt_d     = CNT_W'(1);
            idx_d     = '0;
            rst_out_d = '0;
            running_d = 1'b0;
            timeout_d = 1'b0;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q >= PULSE_LIM) begin
                        state_d      = ST_RELEASE;
                        rst_out_d[0] = 1'b1;
                        idx_d        = IDX_W'(1);
                        cnt_d        = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (idx_q >= IDX_W'(NUM_RST)) begin
                        state_d   = ST_RUN;
                        running_d = 1'b1;
                        cnt_d     = '0;
                    end else if (cnt_q >= STAG_LIM) begin
                        for (int i = 0; i < NUM_RST; i++) begin
                            if (IDX_W'(i) == idx_q) begin
                                rst_out_d[i] = 1'b1;
                            end
                        end
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (done_in) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        running_d = 1'b0;
                    end else if (kick) begin
                        cnt_d = '0;
                    end else if (WDT_EN && (cnt_q >= WDT_LIM)) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                        running_d = 1'b0;
                    end else if (WDT_EN) begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '0;
            running_q <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            running_q <= running_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    assign rst_n_out = rst_out_q;
    assign running   = running_q;
    assign timeout   = timeout_q;
    assign done      = done_q;

`ifdef RST_WDT_STATUS_EN
    logic [31:0] run_cycles_q, run_cycles_d;
    logic [7:0]  sw_rst_cnt_q, sw_rst_cnt_d;

    // The request counter survives software resets; only the pad reset clears it.
    always_comb begin
        run_cycles_d = run_cycles_q;
        sw_rst_cnt_d = sw_rst_cnt_q;
        if (rst_synced && sw_rst_req) begin
            run_cycles_d = '0;
            if (sw_rst_cnt_q != 8'hFF) begin
                sw_rst_cnt_d = sw_rst_cnt_q + 8'd1;
            end
        end else if ((state_q == ST_RUN) && (run_cycles_q != 32'hFFFF_FFFF)) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles_q <= '0;
            sw_rst_cnt_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
            sw_rst_cnt_q <= sw_rst_cnt_d;
        end
    end

    assign run_cycles = run_cycles_q;
    assign sw_rst_cnt = sw_rst_cnt_q;
`endif

endmodule

// File: tb/tb_rst_wdt_ctrl.sv
// Bench for rst_wdt_ctrl: a default instance and a 4-channel, watchdog-disabled instance,
// both compared every cycle against a timeline-based reference model.
module tb_rst_wdt_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int PULSE_W     = 3;
    localparam int STAGGER     = 4;

    typedef enum int {M_SEQ, M_RUN, M_TO, M_DONE} tbMode_e;

    logic clk = 1'b0;
    logic rst_n;
    logic swRstReq0, kick0, doneIn0;
    logic swRstReq1, kick1, doneIn1;
    logic [1:0] rstOut0;
    logic [3:0] rstOut1;
    logic running0, timeout0, done0;
    logic running1, timeout1, done1;
`ifdef RST_WDT_STATUS_EN
    logic [31:0] runCycles0, runCycles1;
    logic [7:0]  swRstCnt0, swRstCnt1;
`endif

    int checks   = 0;
    int failures = 0;
    int edgeNo   = 0;
    int syncEdges = 0;
    tbMode_e mMode[2];
    int mT[2];
    int mLast[2];

    always #5 clk = ~clk;

    rst_wdt_ctrl dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (swRstReq0),
        .kick       (kick0),
        .done_in    (doneIn0),
        .rst_n_out  (rstOut0),
        .running    (running0),
        .timeout    (timeout0),
        .done       (done0)
`ifdef RST_WDT_STATUS_EN
        ,
        .run_cycles (runCycles0),
        .sw_rst_cnt (swRstCnt0)
`endif
    );

    rst_wdt_ctrl #(
        .NUM_RST (4),
        .TIMEOUT (0)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (swRstReq1),
        .kick       (kick1),
        .done_in    (doneIn1),
        .rst_n_out  (rstOut1),
        .running    (running1),
        .timeout    (timeout1),
        .done       (done1)
`ifdef RST_WDT_STATUS_EN
        ,
        .run_cycles (runCycles1),
        .sw_rst_cnt (swRstCnt1)
`endif
    );

    function automatic int numRstOf(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int timeoutOf(int d);
        return (d == 0) ? 50 : 0;
    endfunction

    // Channel i rises PULSE_W + i*STAGGER edges after the sequence start; RUN one edge after the last.
    function automatic int runOffset(int d);
        return PULSE_W + (numRstOf(d) - 1) * STAGGER + 1;
    endfunction

    function automatic logic [7:0] expChannels(int d);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < numRstOf(d); i++) begin
            v[i] = (mMode[d] != M_SEQ) || (mT[d] >= PULSE_W + i * STAGGER);
        end
        return v;
    endfunction

    task automatic resetModel();
        syncEdges = 0;
        for (int d = 0; d < 2; d++) begin
            mMode[d] = M_SEQ;
            mT[d]    = -1;
            mLast[d] = 0;
        end
    endtask

    task automatic modelEdge(input int d, input logic sw, input logic k, input logic dn);
        if (sw) begin
            mMode[d] = M_SEQ;
            mT[d]    = 0;
        end else begin
            case (mMode[d])
                M_SEQ: begin
                    mT[d]++;
                    if (mT[d] >= runOffset(d)) begin
                        mMode[d] = M_RUN;
                        mLast[d] = edgeNo;
                    end
                end
                M_RUN: begin
                    if (dn) mMode[d] = M_DONE;
                    else if (k) mLast[d] = edgeNo;
                    else if (timeoutOf(d) > 0 && edgeNo - mLast[d] >= timeoutOf(d)) mMode[d] = M_TO;
                end
                default: begin
                end
            endcase
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        logic [7:0] e0, e1;
        e0 = expChannels(0);
        e1 = expChannels(1);
        checkOutput("model dut0 rst_n_out", 32'(rstOut0), 32'(e0));
        checkOutput("model dut0 running", 32'(running0), 32'(mMode[0] == M_RUN));
        checkOutput("model dut0 timeout", 32'(timeout0), 32'(mMode[0] == M_TO));
        checkOutput("model dut0 done", 32'(done0), 32'(mMode[0] == M_DONE));
        checkOutput("model dut1 rst_n_out", 32'(rstOut1), 32'(e1));
        checkOutput("model dut1 running", 32'(running1), 32'(mMode[1] == M_RUN));
        checkOutput("model dut1 timeout", 32'(timeout1), 32'(mMode[1] == M_TO));
        checkOutput("model dut1 done", 32'(done1), 32'(mMode[1] == M_DONE));
    endtask

    // Drives one cycle of inputs, advances the model at the edge and compares just after it.
    task automatic applyStimulus(input logic s0, input logic k0, input logic d0,
                                 input logic s1, input logic k1, input logic d1);
        swRstReq0 = s0; kick0 = k0; doneIn0 = d0;
        swRstReq1 = s1; kick1 = k1; doneIn1 = d1;
        @(posedge clk);
        edgeNo++;
        if (!rst_n) begin
            resetModel();
        end else if (syncEdges < SYNC_STAGES) begin
            syncEdges++;
        end else begin
            modelEdge(0, s0, k0, d0);
            modelEdge(1, s1, k1, d1);
        end
        #1;
        checkModel();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    // Call right after rst_n rises; edge n is the n-th clock edge after the rise.
    task automatic checkReleaseTimeline(input string tag);
        for (int n = 0; n < 20; n++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput({tag, " dut0 ch0"}, 32'(rstOut0[0]), 32'(n >= 5));
            checkOutput({tag, " dut0 ch1"}, 32'(rstOut0[1]), 32'(n >= 9));
            checkOutput({tag, " dut0 running"}, 32'(running0), 32'(n >= 10));
            for (int k = 0; k < 4; k++) begin
                checkOutput({tag, " dut1 ch"}, 32'(rstOut1[k]), 32'(n >= 5 + 4 * k));
            end
            checkOutput({tag, " dut1 running"}, 32'(running1), 32'(n >= 18));
        end
    endtask

    initial begin
        int seen;
        swRstReq0 = 0; kick0 = 0; doneIn0 = 0;
        swRstReq1 = 0; kick1 = 0; doneIn1 = 0;
        rst_n = 1'b0;
        resetModel();

        idle(3);
        checkOutput("reset rst_n_out", 32'({rstOut1, rstOut0}), 32'h0);
        checkOutput("reset flags", 32'({running0, timeout0, done0, running1, timeout1, done1}), 32'h0);
        rst_n = 1'b1;
        checkReleaseTimeline("release");

        for (int i = 0; i < 200; i++) applyStimulus(0, (i % 20) == 19, 0, 0, 0, 0);
        checkOutput("kicked no timeout", 32'(timeout0), 32'h0);
        seen = 0;
        for (int j = 1; j <= 100 && seen == 0; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (timeout0 === 1'b1) seen = j;
        end
        checkOutput("timeout latency", 32'(seen), 32'd50);
        checkOutput("timeout running", 32'(running0), 32'h0);

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("swrst from timeout rst_n_out", 32'(rstOut0), 32'h0);
        checkOutput("swrst from timeout flag", 32'(timeout0), 32'h0);
        for (int n = 1; n <= 10; n++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("swrst ch0", 32'(rstOut0[0]), 32'(n >= 3));
            checkOutput("swrst ch1", 32'(rstOut0[1]), 32'(n >= 7));
            checkOutput("swrst running", 32'(running0), 32'(n >= 8));
        end

        applyStimulus(0, 1, 0, 0, 0, 0);
        idle(49);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("kick beats expiry timeout", 32'(timeout0), 32'h0);
        checkOutput("kick beats expiry running", 32'(running0), 32'h1);
        idle(49);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("done beats expiry done", 32'(done0), 32'h1);
        checkOutput("done beats expiry timeout", 32'(timeout0), 32'h0);
        checkOutput("done running", 32'(running0), 32'h0);
        idle(5);
        checkOutput("done sticky", 32'(done0), 32'h1);

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("swrst from done flag", 32'(done0), 32'h0);
        checkOutput("swrst from done rst_n_out", 32'(rstOut0), 32'h0);
        idle(12);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("swrst in run rst_n_out", 32'(rstOut0), 32'h0);
        checkOutput("swrst in run running", 32'(running0), 32'h0);
        idle(4);
        checkOutput("mid release ch", 32'(rstOut0), 32'h1);

        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkOutput("async reset rst_n_out", 32'({rstOut1, rstOut0}), 32'h0);
        checkOutput("async reset flags", 32'({running0, timeout0, done0, running1, timeout1, done1}), 32'h0);
        idle(2);
        rst_n = 1'b1;
        checkReleaseTimeline("rerelease");

        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 59) == 0,
                          $urandom_range(0, 399) == 0, 0, 0, 0);
        end
        checkOutput("no watchdog timeout", 32'(timeout1), 32'h0);
        checkOutput("no watchdog running", 32'(running1), 32'h1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
